// File: rtl/timing_vigilador.sv
// rtl/timing_vigilador.sv - setup/hold violation monitor for an asynchronous flip-flop clock/data bundle
module timing_vigilador #(
    parameter int N_CH    = 4,
    parameter int TSU_CYC = 3,
    parameter int TH_CYC  = 0,
    parameter int MODE    = 0,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_ff,
    input  logic [N_CH-1:0]   i_d_ff,
    input  logic              i_clr,
    output logic [N_CH-1:0]   o_setup_viol,
    output logic [N_CH-1:0]   o_hold_viol,
    output logic              o_alarm,
    output logic [CNT_W-1:0]  o_viol_cnt
);

    localparam logic [7:0] TSU = 8'(TSU_CYC);
    localparam logic [7:0] TH  = 8'(TH_CYC);

    logic              r_s1_clk;
    logic              r_s2_clk;
    logic [N_CH-1:0]   r_s1_d;
    logic [N_CH-1:0]   r_s2_d;
    logic [1:0]        r_arm;
    logic [7:0]        r_age [N_CH];
    logic [7:0]        r_hw;
    logic [N_CH-1:0]   r_setup_viol;
    logic [N_CH-1:0]   r_hold_viol;
    logic              r_alarm;
    logic [CNT_W-1:0]  r_viol_cnt;

    logic              w_live;
    logic              w_edge;
    logic [N_CH-1:0]   w_chg;
    logic [N_CH-1:0]   w_setup_det;
    logic [N_CH-1:0]   w_hold_det;
    logic [N_CH-1:0]   w_setup_nxt;
    logic [N_CH-1:0]   w_hold_nxt;
    logic              w_event;

    // The sample stages refill from zero after reset; edges and changes are
    // ignored until both stages hold real pin values, so data that was
    // stable across reset never looks like a fresh change.
    assign w_live = r_arm[1];
    assign w_edge = w_live & r_s1_clk & ~r_s2_clk;
    assign w_chg  = w_live ? (r_s1_d ^ r_s2_d) : '0;

    always_comb begin
        w_setup_det = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_setup_det[i] = w_edge & (w_chg[i] | (r_age[i] < TSU));
        end
    end

    assign w_hold_det  = (!w_edge && r_hw != 8'd0) ? w_chg : '0;
    assign w_event     = |{w_setup_det, w_hold_det};
    assign w_setup_nxt = i_clr ? w_setup_det : (r_setup_viol | w_setup_det);
    assign w_hold_nxt  = i_clr ? w_hold_det  : (r_hold_viol  | w_hold_det);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_clk     <= 1'b0;
            r_s2_clk     <= 1'b0;
            r_s1_d       <= '0;
            r_s2_d       <= '0;
            r_arm        <= 2'd0;
            for (int i = 0; i < N_CH; i++) begin
                r_age[i] <= TSU;
            end
            r_hw         <= 8'd0;
            r_setup_viol <= '0;
            r_hold_viol  <= '0;
            r_alarm      <= 1'b0;
            r_viol_cnt   <= '0;
        end else begin
            r_s1_clk <= i_clk_ff;
            r_s2_clk <= r_s1_clk;
            r_s1_d   <= i_d_ff;
            r_s2_d   <= r_s1_d;
            if (!r_arm[1]) begin
                r_arm <= r_arm + 2'd1;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (w_chg[i]) begin
                    r_age[i] <= 8'd0;
                end else if (r_age[i] < TSU) begin
                    r_age[i] <= r_age[i] + 8'd1;
                end
            end
            if (w_edge) begin
                r_hw <= TH;
            end else if (r_hw != 8'd0) begin
                r_hw <= r_hw - 8'd1;
            end
            r_setup_viol <= w_setup_nxt;
            r_hold_viol  <= w_hold_nxt;
            if (i_clr) begin
                r_viol_cnt <= w_event ? CNT_W'(1) : '0;
            end else if (w_event && !(&r_viol_cnt)) begin
                r_viol_cnt <= r_viol_cnt + CNT_W'(1);
            end
            r_alarm <= (MODE == 0) ? w_event : |{w_setup_nxt, w_hold_nxt};
        end
    end

    assign o_setup_viol = r_setup_viol;
    assign o_hold_viol  = r_hold_viol;
    assign o_alarm      = r_alarm;
    assign o_viol_cnt   = r_viol_cnt;

endmodule

// File: tb/tb_timing_vigilador.sv
// tb/tb_timing_vigilador.sv - scoreboard bench for timing_vigilador, pulse/16-bit and level/2-bit instances
module tb_timing_vigilador;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_ff;
    logic        clr;
    logic [3:0]  d;

    logic [3:0]  a_setup, a_hold, b_setup, b_hold;
    logic        a_alarm, b_alarm;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  s;
        logic [3:0]  h;
        logic [15:0] c;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    timing_vigilador #(.N_CH(4), .TSU_CYC(3), .TH_CYC(2), .MODE(0), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_clk_ff(clk_ff), .i_d_ff(d), .i_clr(clr),
        .o_setup_viol(a_setup), .o_hold_viol(a_hold), .o_alarm(a_alarm), .o_viol_cnt(a_cnt)
    );

    timing_vigilador #(.N_CH(4), .TSU_CYC(3), .TH_CYC(0), .MODE(1), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clk_ff(clk_ff), .i_d_ff(d), .i_clr(clr),
        .o_setup_viol(b_setup), .o_hold_viol(b_hold), .o_alarm(b_alarm), .o_viol_cnt(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag,
                             input logic [3:0] as, input logic [3:0] ah, input logic [15:0] ac,
                             input logic [3:0] bs, input logic [3:0] bh, input logic [1:0] bc,
                             input logic bal);
        chk({tag, ".a_setup"}, 32'(a_setup), 32'(as));
        chk({tag, ".a_hold"},  32'(a_hold),  32'(ah));
        chk({tag, ".a_cnt"},   32'(a_cnt),   32'(ac));
        chk({tag, ".b_setup"}, 32'(b_setup), 32'(bs));
        chk({tag, ".b_hold"},  32'(b_hold),  32'(bh));
        chk({tag, ".b_cnt"},   32'(b_cnt),   32'(bc));
        chk({tag, ".b_alarm"}, 32'(b_alarm), 32'(bal));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(2);
    endtask

    // Each alarm pulse of the pulse-mode instance consumes one expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && a_alarm === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon.unexpected_alarm: got alarm with setup %0h hold %0h cnt %0d, expected none",
                         a_setup, a_hold, a_cnt);
            end else begin
                e = sb.pop_front();
                chk("mon.setup", 32'(a_setup), 32'(e.s));
                chk("mon.hold",  32'(a_hold),  32'(e.h));
                chk("mon.cnt",   32'(a_cnt),   32'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clk_ff = 1'b0; d = 4'b0000; clr = 1'b0;
        step(3);
        chk_state("in_rst", 0, 0, 0, 0, 0, 0, 0);
        chk("in_rst.a_alarm", 32'(a_alarm), 0);
        rst = 1'b0;
        step(4);
        chk_state("post_rst", 0, 0, 0, 0, 0, 0, 0);

        // d[0] settles 5 cycles before the rise: clean
        d[0] = ~d[0];
        step(5);
        clk_ff = 1'b1;
        step(2);
        clk_ff = 1'b0;
        step(6);
        chk_state("early_data", 0, 0, 0, 0, 0, 0, 0);

        // d[2] changes 2 cycles before the rise: setup violation
        d[2] = ~d[2];
        step(2);
        clk_ff = 1'b1;
        sb.push_back('{4'b0100, 4'b0000, 16'd1});
        step(1);
        chk("setup2.not_early", 32'(a_setup), 0);
        step(1);
        chk("setup2.flag", 32'(a_setup), 32'h4);
        clk_ff = 1'b0;
        step(5);
        chk_state("setup2", 4'b0100, 0, 1, 4'b0100, 0, 1, 1);
        do_clr();
        chk_state("setup2_clr", 0, 0, 0, 0, 0, 0, 0);

        // d[1] changes 1 cycle after the rise: hold violation only where enabled
        clk_ff = 1'b1;
        sb.push_back('{4'b0000, 4'b0010, 16'd1});
        step(1);
        d[1] = ~d[1];
        step(2);
        clk_ff = 1'b0;
        step(5);
        chk_state("hold1", 0, 4'b0010, 1, 0, 0, 0, 0);
        do_clr();

        // d[0] and d[3] change together 1 cycle before the rise: one event
        d[0] = ~d[0];
        d[3] = ~d[3];
        step(1);
        clk_ff = 1'b1;
        sb.push_back('{4'b1001, 4'b0000, 16'd1});
        step(2);
        clk_ff = 1'b0;
        step(5);
        chk_state("dual", 4'b1001, 0, 1, 4'b1001, 0, 1, 1);
        step(10);
        chk("dual.b_alarm_held", 32'(b_alarm), 1);
        do_clr();
        chk_state("dual_clr", 0, 0, 0, 0, 0, 0, 0);

        // five violating edges: 2-bit counter saturates at 3
        for (int i = 1; i <= 5; i++) begin
            d[2] = ~d[2];
            step(1);
            clk_ff = 1'b1;
            sb.push_back('{4'b0100, 4'b0000, 16'(i)});
            step(2);
            clk_ff = 1'b0;
            step(2);
        end
        step(3);
        chk_state("sat", 4'b0100, 0, 5, 4'b0100, 0, 3, 1);

        // sixth event with a coincident clear
        d[1] = ~d[1];
        step(1);
        clk_ff = 1'b1;
        sb.push_back('{4'b0010, 4'b0000, 16'd1});
        step(1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        clk_ff = 1'b0;
        step(4);
        chk_state("clr_event", 4'b0010, 0, 1, 4'b0010, 0, 1, 1);
        do_clr();

        // reset inside the hold window, then a late toggle
        clk_ff = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_state("rst_win", 0, 0, 0, 0, 0, 0, 0);
        chk("rst_win.a_alarm", 32'(a_alarm), 0);
        step(1);
        clk_ff = 1'b0;
        step(1);
        d[1] = ~d[1];
        step(6);
        chk_state("rst_after", 0, 0, 0, 0, 0, 0, 0);

        step(2);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
